// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destinations, selects operand forwarding
// and raises load-use stalls. Optional counters under HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic [4:0]            issue_rs1_i,
  input  logic [4:0]            issue_rs2_i,
  input  logic                  issue_rs1_used_i,
  input  logic                  issue_rs2_used_i,
  input  logic [4:0]            issue_rd_i,
  input  logic                  issue_we_i,
  input  logic                  issue_is_load_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       rf_data1_i,
  input  logic [XLEN-1:0]       rf_data2_i,
  input  logic [DEPTH*XLEN-1:0] stage_data_i,
  output logic                  stall_o,
  output logic [3:0]            fwd_sel1_o,
  output logic [3:0]            fwd_sel2_o,
  output logic [XLEN-1:0]       opnd1_o,
  output logic [XLEN-1:0]       opnd2_o
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           fwd_cnt_o
`endif
);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_we;
  logic [DEPTH-1:0] ent_load;
  logic [4:0]       ent_rd [DEPTH];

  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic             hazard;

  always_comb begin
    match1 = '0;
    match2 = '0;
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      match1[k] = ent_valid[k] && ent_we[k] && (ent_rd[k] == issue_rs1_i) &&
                  (issue_rs1_i != 5'd0) && issue_rs1_used_i;
      match2[k] = ent_valid[k] && ent_we[k] && (ent_rd[k] == issue_rs2_i) &&
                  (issue_rs2_i != 5'd0) && issue_rs2_used_i;
      if ((k < LOAD_LAT) && ent_load[k] && (match1[k] || match2[k]))
        hazard = 1'b1;
    end
  end

  assign stall_o = issue_valid_i && !flush_i && hazard;

  // Walk oldest to youngest so the youngest eligible entry wins; loads whose
  // data is not yet available are never forwarded from.
  always_comb begin
    fwd_sel1_o = 4'd0;
    fwd_sel2_o = 4'd0;
    opnd1_o    = rf_data1_i;
    opnd2_o    = rf_data2_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match1[k] && !((k < LOAD_LAT) && ent_load[k])) begin
        fwd_sel1_o = 4'(k + 1);
        opnd1_o    = stage_data_i[k*XLEN +: XLEN];
      end
      if (match2[k] && !((k < LOAD_LAT) && ent_load[k])) begin
        fwd_sel2_o = 4'(k + 1);
        opnd2_o    = stage_data_i[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_we    <= '0;
      ent_load  <= '0;
      for (int k = 0; k < DEPTH; k++) ent_rd[k] <= 5'd0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_we[k]    <= ent_we[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_rd[k]    <= ent_rd[k-1];
      end
      ent_valid[0] <= issue_valid_i && !stall_o && !flush_i;
      ent_we[0]    <= issue_we_i;
      ent_load[0]  <= issue_is_load_i;
      ent_rd[0]    <= issue_rd_i;
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (((fwd_sel1_o != 4'd0) || (fwd_sel2_o != 4'd0)) && (fwd_cnt_o != 32'hFFFF_FFFF))
        fwd_cnt_o <= fwd_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios plus randomized
// traffic checked against a behavioural model of in-flight instructions.
module tb_hazard_scoreboard;
  localparam int XLEN     = 32;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  issue_valid_i;
  logic [4:0]            issue_rs1_i, issue_rs2_i;
  logic                  issue_rs1_used_i, issue_rs2_used_i;
  logic [4:0]            issue_rd_i;
  logic                  issue_we_i, issue_is_load_i, flush_i;
  logic [XLEN-1:0]       rf_data1_i, rf_data2_i;
  logic [DEPTH*XLEN-1:0] stage_data_i;
  logic                  stall_o;
  logic [3:0]            fwd_sel1_o, fwd_sel2_o;
  logic [XLEN-1:0]       opnd1_o, opnd2_o;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0]           stall_cnt_o, fwd_cnt_o;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs1_used_i(issue_rs1_used_i), .issue_rs2_used_i(issue_rs2_used_i),
    .issue_rd_i(issue_rd_i), .issue_we_i(issue_we_i), .issue_is_load_i(issue_is_load_i),
    .flush_i(flush_i), .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i),
    .stage_data_i(stage_data_i), .stall_o(stall_o),
    .fwd_sel1_o(fwd_sel1_o), .fwd_sel2_o(fwd_sel2_o),
    .opnd1_o(opnd1_o), .opnd2_o(opnd2_o)
`ifdef HAZARD_SCOREBOARD_STATS_EN
    , .stall_cnt_o(stall_cnt_o), .fwd_cnt_o(fwd_cnt_o)
`endif
  );

  typedef struct {
    bit v; logic [4:0] rs1; bit u1; logic [4:0] rs2; bit u2;
    logic [4:0] rd; bit we; bit ld; bit fl; bit rst;
  } stim_t;

  typedef struct {
    bit stall; logic [3:0] sel1; logic [3:0] sel2;
    logic [XLEN-1:0] op1; logic [XLEN-1:0] op2;
    logic [31:0] stall_cnt; logic [31:0] fwd_cnt;
    string name;
  } exp_t;

  typedef struct { bit v; bit we; bit ld; logic [4:0] rd; } instr_t;

  // Model: instructions in flight, index = age in cycles since issue.
  instr_t      pipe [DEPTH];
  logic [31:0] m_stall_cnt, m_fwd_cnt;
  exp_t        expq [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [XLEN-1:0] pick(input logic [3:0] sel,
                                            input logic [DEPTH*XLEN-1:0] sd,
                                            input logic [XLEN-1:0] rf);
    if (sel == 4'd0) return rf;
    return sd[(int'(sel) - 1)*XLEN +: XLEN];
  endfunction

  // Does the instruction of a given age write this register in a way a reader sees?
  function automatic bit writes(input int age, input logic [4:0] r, input bit used);
    return used && r != 5'd0 && pipe[age].v && pipe[age].we && pipe[age].rd == r;
  endfunction

  function automatic logic [3:0] src_sel(input logic [4:0] r, input bit used);
    for (int age = 0; age < DEPTH; age++)
      if (writes(age, r, used) && !(pipe[age].ld && age < LOAD_LAT))
        return 4'(age + 1);
    return 4'd0;
  endfunction

  function automatic exp_t model_eval(input stim_t s, input logic [DEPTH*XLEN-1:0] sd,
                                      input logic [XLEN-1:0] rf1, input logic [XLEN-1:0] rf2);
    exp_t e;
    bit   load_use = 1'b0;
    for (int age = 0; age < LOAD_LAT; age++)
      if (pipe[age].ld && (writes(age, s.rs1, s.u1) || writes(age, s.rs2, s.u2)))
        load_use = 1'b1;
    e.stall     = s.v && !s.fl && load_use;
    e.sel1      = src_sel(s.rs1, s.u1);
    e.sel2      = src_sel(s.rs2, s.u2);
    e.op1       = pick(e.sel1, sd, rf1);
    e.op2       = pick(e.sel2, sd, rf2);
    e.stall_cnt = m_stall_cnt;
    e.fwd_cnt   = m_fwd_cnt;
    e.name      = "";
    return e;
  endfunction

  task automatic model_update(input stim_t s, input exp_t m);
    if (s.rst) begin
      foreach (pipe[i]) pipe[i] = '{1'b0, 1'b0, 1'b0, 5'd0};
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
    end else begin
      for (int age = DEPTH - 1; age > 0; age--) pipe[age] = pipe[age-1];
      pipe[0] = '{s.v && !m.stall && !s.fl, s.we, s.ld, s.rd};
      if (m.stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if ((m.sel1 != 0 || m.sel2 != 0) && m_fwd_cnt != 32'hFFFF_FFFF) m_fwd_cnt++;
    end
  endtask

  function automatic stim_t mk(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                               input int rd, input bit we, input bit ld, input bit fl, input bit r);
    stim_t s;
    s = '{v, 5'(rs1), u1, 5'(rs2), u2, 5'(rd), we, ld, fl, r};
    return s;
  endfunction

  function automatic exp_t dx(input bit st, input int s1, input int s2);
    exp_t e;
    e.stall = st; e.sel1 = 4'(s1); e.sel2 = 4'(s2);
    e.op1 = '0; e.op2 = '0; e.stall_cnt = '0; e.fwd_cnt = '0; e.name = "";
    return e;
  endfunction

  function automatic logic [DEPTH*XLEN-1:0] rand_sd();
    logic [DEPTH*XLEN-1:0] sd;
    for (int k = 0; k < DEPTH; k++) sd[k*XLEN +: XLEN] = $urandom;
    return sd;
  endfunction

  task automatic step(input stim_t s, input logic [DEPTH*XLEN-1:0] sd,
                      input bit dir, input exp_t de, input string nm);
    exp_t m, e;
    issue_valid_i = s.v;  issue_rs1_i = s.rs1; issue_rs1_used_i = s.u1;
    issue_rs2_i = s.rs2;  issue_rs2_used_i = s.u2; issue_rd_i = s.rd;
    issue_we_i = s.we;    issue_is_load_i = s.ld; flush_i = s.fl; rst = s.rst;
    stage_data_i = sd;    rf_data1_i = $urandom; rf_data2_i = $urandom;
    m = model_eval(s, sd, rf_data1_i, rf_data2_i);
    e = m;
    if (dir) begin
      e.stall = de.stall; e.sel1 = de.sel1; e.sel2 = de.sel2;
      e.op1 = pick(de.sel1, sd, rf_data1_i);
      e.op2 = pick(de.sel2, sd, rf_data2_i);
    end
    e.name = nm;
    expq.push_back(e);
    @(posedge clk);
    model_update(s, m);
    #1;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk({e.name, ".stall"}, 32'(stall_o),    32'(e.stall));
      chk({e.name, ".sel1"},  32'(fwd_sel1_o), 32'(e.sel1));
      chk({e.name, ".sel2"},  32'(fwd_sel2_o), 32'(e.sel2));
      chk({e.name, ".opnd1"}, 32'(opnd1_o),    32'(e.op1));
      chk({e.name, ".opnd2"}, 32'(opnd2_o),    32'(e.op2));
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk({e.name, ".stall_cnt"}, stall_cnt_o, e.stall_cnt);
      chk({e.name, ".fwd_cnt"},   fwd_cnt_o,   e.fwd_cnt);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d checks pending", expq.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [DEPTH*XLEN-1:0] sd;
    stim_t nop, lw7;
    exp_t  z;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw7 = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    z   = dx(0, 0, 0);

    rst = 1'b1; issue_valid_i = 0; issue_rs1_i = 0; issue_rs2_i = 0;
    issue_rs1_used_i = 0; issue_rs2_used_i = 0; issue_rd_i = 0; issue_we_i = 0;
    issue_is_load_i = 0; flush_i = 0; rf_data1_i = 0; rf_data2_i = 0; stage_data_i = '0;
    repeat (2) @(posedge clk);
    foreach (pipe[i]) pipe[i] = '{1'b0, 1'b0, 1'b0, 5'd0};
    m_stall_cnt = 0; m_fwd_cnt = 0;
    #1;

    step(mk(1, 3, 1, 4, 1, 0, 0, 0, 0, 0), rand_sd(), 1, z, "after_reset");

    step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0), rand_sd(), 1, z, "fwd_addi");
    sd = rand_sd(); sd[0 +: XLEN] = 32'h1234;
    step(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0), sd, 1, dx(0, 1, 0), "fwd_e0");

    step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0), rand_sd(), 1, z, "young_w1");
    step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0), rand_sd(), 1, z, "young_w2");
    sd = rand_sd(); sd[0 +: XLEN] = 32'hAAAA; sd[XLEN +: XLEN] = 32'hBBBB;
    step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0), sd, 1, dx(0, 1, 0), "youngest");
    repeat (DEPTH) step(nop, rand_sd(), 1, z, "drain");

    step(lw7, rand_sd(), 1, z, "lu_load");
    step(mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 0), rand_sd(), 1, dx(1, 0, 0), "lu_stall");
    sd = rand_sd(); sd[XLEN +: XLEN] = 32'hDEAD_0007;
    step(mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 0), sd, 1, dx(0, 0, 2), "lu_issue");
    repeat (DEPTH) step(nop, rand_sd(), 1, z, "drain");

    step(lw7, rand_sd(), 1, z, "fl_load");
    step(mk(1, 0, 0, 7, 1, 9, 1, 0, 1, 0), rand_sd(), 1, z, "fl_flush");
    step(mk(1, 9, 1, 7, 1, 10, 1, 0, 0, 0), rand_sd(), 1, dx(0, 0, 2), "fl_after");
    repeat (DEPTH) step(nop, rand_sd(), 1, z, "drain");

    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0), rand_sd(), 1, z, "x0_write");
    step(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0), rand_sd(), 1, z, "x0_read");
    repeat (DEPTH) step(nop, rand_sd(), 1, z, "drain");

    step(lw7, rand_sd(), 1, z, "rst_load");
    step(mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 1), rand_sd(), 1, dx(1, 0, 0), "rst_stall");
    step(mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 0), rand_sd(), 1, z, "rst_after");

    for (int i = 0; i < 2000; i++) begin
      stim_t s;
      s = mk($urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 63) == 0);
      step(s, rand_sd(), 0, z, "rand");
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
